// File: rtl/mfp_als_spi_controller_if.sv
// Host/sensor-facing signal bundle of the PmodALS SPI controller.
// The controller takes the master modport; the host register file and sensor take slave.
interface mfp_als_spi_controller_if;
    logic        start;
    logic        auto_en;
    logic        busy;
    logic [7:0]  value;
    logic [15:0] frame;
    logic        value_valid;
    logic        frame_err;
    logic        SPI_CS;
    logic        SPI_SCK;
    logic        SPI_SDO;

    modport master (
        input  start, auto_en, SPI_SDO,
        output busy, value, frame, value_valid, frame_err, SPI_CS, SPI_SCK
    );

    modport slave (
        output start, auto_en, SPI_SDO,
        input  busy, value, frame, value_valid, frame_err, SPI_CS, SPI_SCK
    );
endinterface

// File: rtl/mfp_als_spi_controller.sv
// SPI master and sample scheduler for the PmodALS light sensor: merges software and
// periodic requests, frames 16-bit reads and holds the extracted 8-bit light value.
module mfp_als_spi_controller #(
    parameter int CLK_DIV = 8,
    parameter int PERIOD  = 100000,
    parameter int QUIET   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    mfp_als_spi_controller_if.master  bus
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int TMR_W = $clog2(PERIOD);
    localparam int Q_W   = $clog2(QUIET + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PERIOD - 1);
    localparam logic [Q_W-1:0]   Q_INIT   = Q_W'(QUIET);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE, S_QUIET} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              sck_q, sck_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              pending_q, pending_d;
    logic              cs_q, cs_d;
    logic [15:0]       sr_q, sr_d;
    logic [4:0]        bitcnt_q, bitcnt_d;
    logic [Q_W-1:0]    qcnt_q, qcnt_d;
    logic [15:0]       frame_q, frame_d;
    logic [7:0]        value_q, value_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;

    logic div_term, rise_tick, fall_tick, timer_exp, frame_begin;

    assign div_term    = (div_q == DIV_LAST);
    assign rise_tick   = div_term && !sck_q;
    assign fall_tick   = div_term && sck_q;
    assign timer_exp   = bus.auto_en && (timer_q == TMR_LAST);
    assign frame_begin = (state_q == S_IDLE) && pending_q && rise_tick;

    // State register: every flop of the block, reset synchronously.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples values from before the edge.
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            sck_q     <= 1'b1;
            timer_q   <= '0;
            pending_q <= 1'b0;
            cs_q      <= 1'b1;
            sr_q      <= '0;
            bitcnt_q  <= '0;
            qcnt_q    <= '0;
            frame_q   <= '0;
            value_q   <= '0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            sck_q     <= sck_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            cs_q      <= cs_d;
            sr_q      <= sr_d;
            bitcnt_q  <= bitcnt_d;
            qcnt_q    <= qcnt_d;
            frame_q   <= frame_d;
            value_q   <= value_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
        end
    end

    // Free-running SCK, auto-sample timer and the single-entry request latch.
    always_comb begin
        div_d = div_term ? '0 : div_q + DIV_W'(1);
        sck_d = div_term ? !sck_q : sck_q;

        if (!bus.auto_en || timer_q == TMR_LAST) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TMR_W'(1);
        end

        // A request coinciding with frame start is the one that frame services.
        pending_d = frame_begin ? 1'b0 : (pending_q || bus.start || timer_exp);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (pending_q && rise_tick) state_d = S_SHIFT;
            S_SHIFT: if (rise_tick && bitcnt_q == 5'd15) state_d = S_DONE;
            S_DONE:  state_d = S_QUIET;
            S_QUIET: if (qcnt_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        // NOTE: hold-value defaults first, so no branch leaves a signal unassigned (no latch).
        cs_d     = cs_q;
        sr_d     = sr_q;
        bitcnt_d = bitcnt_q;
        qcnt_d   = qcnt_q;
        frame_d  = frame_q;
        value_d  = value_q;
        err_d    = err_q;
        valid_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (frame_begin) begin
                    cs_d     = 1'b0;
                    bitcnt_d = '0;
                end
            end
            S_SHIFT: begin
                if (rise_tick) begin
                    sr_d     = {sr_q[14:0], bus.SPI_SDO};
                    bitcnt_d = (bitcnt_q == 5'd16) ? 5'd16 : bitcnt_q + 5'd1;
                    if (bitcnt_q == 5'd15) cs_d = 1'b1;
                end
            end
            S_DONE: begin
                frame_d = sr_q;
                value_d = sr_q[11:4];
                err_d   = (sr_q[15:12] != 4'h0) || (sr_q[3:0] != 4'h0);
                valid_d = 1'b1;
                qcnt_d  = Q_INIT;
            end
            S_QUIET: begin
                if (fall_tick && qcnt_q != '0) qcnt_d = qcnt_q - Q_W'(1);
            end
            default: ;
        endcase
    end

    assign bus.busy        = (state_q != S_IDLE) || pending_q;
    assign bus.value       = value_q;
    assign bus.frame       = frame_q;
    assign bus.value_valid = valid_q;
    assign bus.frame_err   = err_q;
    assign bus.SPI_CS      = cs_q;
    assign bus.SPI_SCK     = sck_q;

endmodule

// File: tb/tb_mfp_als_spi_controller.sv
// Directed bench for mfp_als_spi_controller with a PmodALS sensor stub and a
// queue of expected frames popped on each value_valid pulse.
module tb_mfp_als_spi_controller;

    localparam int CLK_DIV = 2;
    localparam int PERIOD  = 200;

    typedef struct {
        logic [15:0] frame;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    mfp_als_spi_controller_if bus();

    mfp_als_spi_controller #(.CLK_DIV(CLK_DIV), .PERIOD(PERIOD), .QUIET(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = !clk;

    // Sensor stub: loads {0000, value, 0000} when CS falls, shifts MSB first on SCK falls.
    logic [15:0] stub_sr  = 16'h0;
    logic [7:0]  stub_val = 8'h00;
    logic        stub_bit = 1'b0;
    bit          tie_one  = 1'b0;

    always @(negedge bus.SPI_CS) stub_sr = {4'h0, stub_val, 4'h0};
    always @(negedge bus.SPI_SCK) begin
        if (!bus.SPI_CS) begin
            stub_bit = stub_sr[15];
            stub_sr  = {stub_sr[14:0], 1'b0};
        end
    end
    assign bus.SPI_SDO = tie_one ? 1'b1 : stub_bit;

    // Bus monitor, sampled on the falling clock edge.
    int   cyc = 0, cs_fall_cyc = 0, cs_rise_cyc = 0, cs_low_len = 0, rises = 0, valid_cnt = 0;
    logic prev_cs = 1'b1, prev_sck = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (prev_cs && !bus.SPI_CS) begin
            cs_fall_cyc = cyc;
            rises       = 0;
        end
        if (!prev_cs && bus.SPI_CS) begin
            cs_rise_cyc = cyc;
            cs_low_len  = cyc - cs_fall_cyc;
        end
        if (!prev_cs && !bus.SPI_CS && !prev_sck && bus.SPI_SCK) rises++;
        if (bus.value_valid) valid_cnt++;
        prev_cs  = bus.SPI_CS;
        prev_sck = bus.SPI_SCK;
    end

    exp_t sb[$];
    int   n_pass = 0, n_fail = 0, n_total = 0;
    int   last_valid_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_cs_fall(input string tag, input int budget);
        int n = 0;
        while (bus.SPI_CS === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (bus.SPI_CS !== 1'b0) check({tag, "_cs_fall_timeout"}, bus.SPI_CS, 1'b0);
    endtask

    // Waits for a value_valid pulse, compares it against the scoreboard head,
    // then confirms the pulse lasts exactly one cycle.
    task automatic wait_valid(input string tag, input int budget);
        int   n = 0;
        exp_t e;
        while (bus.value_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (bus.value_valid !== 1'b1) begin
            check({tag, "_valid_timeout"}, bus.value_valid, 1'b1);
            return;
        end
        last_valid_cyc = cyc;
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, "_frame"}, bus.frame, e.frame);
        check({tag, "_value"}, bus.value, e.frame[11:4]);
        check({tag, "_frame_err"}, bus.frame_err, e.err);
        tick();
        check({tag, "_valid_one_cycle"}, bus.value_valid, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_cyc, lat, r1, gap, base, n;
        int t[5];

        // Reset, with start held high throughout so it must be ignored.
        rst         = 1'b1;
        bus.start   = 1'b1;
        bus.auto_en = 1'b0;
        repeat (3) tick();
        check("rst_cs", bus.SPI_CS, 1'b1);
        check("rst_sck", bus.SPI_SCK, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_value", bus.value, 8'h00);
        check("rst_frame", bus.frame, 16'h0000);
        check("rst_valid", bus.value_valid, 1'b0);
        check("rst_err", bus.frame_err, 1'b0);
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (20) tick();
        check("idle_busy", bus.busy, 1'b0);
        check("idle_cs", bus.SPI_CS, 1'b1);
        check("idle_no_valid", valid_cnt, 0);

        // Single read.
        stub_val = 8'hAB;
        sb.push_back('{16'h0AB0, 1'b0});
        start_cyc = cyc;
        pulse_start();
        check("single_busy", bus.busy, 1'b1);
        wait_cs_fall("single", 20);
        lat = cs_fall_cyc - start_cyc;
        check("single_start_latency", 32'(lat >= 1 && lat <= 2 * CLK_DIV + 1), 32'd1);
        wait_valid("single", 200);
        check("single_cs_low_len", cs_low_len, 16 * 2 * CLK_DIV);
        repeat (50) tick();
        check("single_valid_count", valid_cnt, 1);
        check("single_idle_busy", bus.busy, 1'b0);

        // Three starts during one frame collapse into one extra frame.
        stub_val = 8'h5A;
        sb.push_back('{16'h05A0, 1'b0});
        pulse_start();
        wait_cs_fall("b2b", 20);
        repeat (10) tick();
        sb.push_back('{16'h05A0, 1'b0});
        for (int i = 0; i < 3; i++) begin
            pulse_start();
            repeat (4) tick();
        end
        check("b2b_cs_still_low", bus.SPI_CS, 1'b0);
        wait_valid("b2b_first", 200);
        r1 = cs_rise_cyc;
        wait_valid("b2b_second", 200);
        gap = cs_fall_cyc - r1;
        check("b2b_gap_min", 32'(gap >= 2 * CLK_DIV), 32'd1);
        check("b2b_gap_max", 32'(gap <= 4 * CLK_DIV), 32'd1);
        repeat (100) tick();
        check("b2b_valid_count", valid_cnt, 3);

        // SDO stuck high: every pad bit set.
        tie_one = 1'b1;
        sb.push_back('{16'hFFFF, 1'b1});
        pulse_start();
        wait_valid("err", 200);
        tie_one = 1'b0;
        repeat (20) tick();

        // Reset after seven sampled bits aborts the frame.
        stub_val = 8'hAB;
        pulse_start();
        wait_cs_fall("rstmid", 20);
        n = 0;
        while (rises < 7 && n < 200) begin
            tick();
            n++;
        end
        check("rstmid_seven_bits", rises, 7);
        base = valid_cnt;
        rst  = 1'b1;
        tick();
        check("rstmid_cs", bus.SPI_CS, 1'b1);
        check("rstmid_sck", bus.SPI_SCK, 1'b1);
        check("rstmid_busy", bus.busy, 1'b0);
        check("rstmid_value", bus.value, 8'h00);
        check("rstmid_valid", bus.value_valid, 1'b0);
        rst = 1'b0;
        repeat (100) tick();
        check("rstmid_no_valid", valid_cnt, base);
        sb.push_back('{16'h0AB0, 1'b0});
        pulse_start();
        wait_valid("after_rst", 200);

        // Periodic sampling.
        stub_val    = 8'h3C;
        bus.auto_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{16'h03C0, 1'b0});
            wait_valid($sformatf("periodic%0d", i), 400);
            t[i] = last_valid_cyc;
        end
        for (int i = 1; i < 5; i++) begin
            check($sformatf("periodic_spacing%0d", i), t[i] - t[i-1], PERIOD);
        end
        wait_cs_fall("periodic_last", 300);
        bus.auto_en = 1'b0;
        sb.push_back('{16'h03C0, 1'b0});
        wait_valid("periodic_last", 200);
        base = valid_cnt;
        repeat (500) tick();
        check("periodic_stopped", valid_cnt, base);
        check("periodic_idle_busy", bus.busy, 1'b0);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mfp_als_spi_controller.md
# mfp_als_spi_controller

SPI master and sampling scheduler for the PmodALS ambient-light sensor in the MIPSfpga+ light-sensor demo (`MFP_DEMO_LIGHT_SENSOR`). It frames 16-bit read transactions on `SPI_CS`/`SPI_SCK`/`SPI_SDO` and merges software-triggered and periodic sample requests into a single sequencer. It extracts the 8-bit light value and holds it for the AHB-Lite I/O register file.

## Interface
Parameters:
- `CLK_DIV`, default 8: `clk` cycles per SCK half-period; must be ≥ 2.
- `PERIOD`, default 100000: `clk` cycles between automatic sample requests; must be ≥ 2.
- `QUIET`, default 1: minimum number of full SCK periods that CS is held high between frames; must be ≥ 1.

Ports:
- `clk` (in, 1): system clock. One clock domain; all logic runs on its rising edge.
- `rst` (in, 1): reset, synchronous and active-high.
- `start` (in, 1): one-cycle software sample request.
- `auto_en` (in, 1): enables periodic sampling.
- `busy` (out, 1): a request is pending or a frame is in progress.
- `value` (out, 8): last light value, `frame[11:4]`.
- `frame` (out, 16): last raw frame.
- `value_valid` (out, 1): one-cycle pulse when `value`/`frame` are updated.
- `frame_err` (out, 1): last frame had a nonzero pad nibble.
- `SPI_CS` (out, 1): chip select, active low.
- `SPI_SCK` (out, 1): serial clock.
- `SPI_SDO` (in, 1): sensor data. The sensor changes it on SCK falling edges.

## Operation
- **SCK generator**
  - Divider counts `0..CLK_DIV-1` and toggles SCK on the terminal count.
  - SCK runs continuously, including while CS is high, so the sensor can reload its shift register.
  - `rise_tick` = the cycle in which SCK goes 0→1; `fall_tick` = the cycle in which SCK goes 1→0.
- **Request merge**
  - `pending` is set by `start` or by a timer expiry. It is cleared when a frame begins.
  - Requests that arrive while `pending` is already set collapse into it; there is no queue.
  - `start` during a frame sets `pending`, and that request is serviced after QUIET.
- **Timer**
  - Held at 0 while `auto_en` = 0.
  - Otherwise counts `0..PERIOD-1`; at `PERIOD-1` it sets `pending` and wraps to 0.
- **FSM**
  - IDLE: on `pending && rise_tick`, drive CS←0, clear `pending`, set bitcnt←0, go to SHIFT.
  - SHIFT: on each `rise_tick`, shift `SPI_SDO` into `sr` (MSB first) and increment bitcnt. On the 16th sample, drive CS←1 and go to DONE.
  - DONE (one cycle): `frame`←`sr`, `value`←`sr[11:4]`, `frame_err`←(`sr[15:12]`≠0 or `sr[3:0]`≠0), pulse `value_valid`. Load qcnt←QUIET and go to QUIET.
  - QUIET: decrement qcnt on each `fall_tick`; at 0 go to IDLE.
- **Busy:** `busy` = (state ≠ IDLE) or `pending`.
- **Reset:** `rst` asserted mid-frame aborts the frame in that cycle. The partial `sr` is discarded, `pending` is cleared, and no `value_valid` is issued.

## Timing
- **Reset values:** `SPI_CS`=1, `SPI_SCK`=1, divider=0, `busy`=0, `value`=0, `frame`=0, `value_valid`=0, `frame_err`=0, `pending`=0, timer=0, state=IDLE.
- **CS window:** low for exactly 16·2·`CLK_DIV` `clk` cycles. It falls on a rise_tick and rises on the 16th following rise_tick.
- **First data bit:** the sensor drives bit 15 on the first SCK fall after CS falls. The master samples on the next rise, half an SCK period later, so data is stable at sampling.
- **Output update:** `value_valid` pulses in the cycle after CS rises; `value`/`frame`/`frame_err` change in that same cycle.
- **Start latency:** `start` → CS fall takes 1 to 2·`CLK_DIV`+1 cycles.
- **Minimum CS-high time between frames:** QUIET·2·`CLK_DIV` cycles, which includes at least one SCK fall.
- **Simultaneous `start` and timer expiry:** a single request.
- **`rst` in the same cycle as `start`:** `rst` wins.
- **Widths:** bitcnt is 5 bits, saturating at 16. Divider, timer and qcnt are sized with `$clog2` of their parameter.

## Test plan
- **Single read:** `CLK_DIV`=2, sensor stub value 8'hAB; one `start` pulse → CS low for 64 cycles, then `frame`=16'h0AB0, `value`=8'hAB, `frame_err`=0, and one `value_valid` pulse.
- **Back-to-back requests:** stub value 8'h5A; `start` pulsed 3 times during one frame → exactly two frames; the second CS fall is ≥ 4 cycles after the first CS rise; `value`=8'h5A both times.
- **Periodic sampling:** `auto_en`=1, `PERIOD`=200, `CLK_DIV`=2; run 1000 cycles → 5 `value_valid` pulses spaced 200 cycles apart. Dropping `auto_en` stops further frames after the current one.
- **Error detection:** `SPI_SDO` tied to 1 → `frame`=16'hFFFF, `value`=8'hFF, `frame_err`=1.
- **Reset mid-frame:** `rst` asserted after 7 sampled bits → next cycle `SPI_CS`=1, `SPI_SCK`=1, `busy`=0, no `value_valid`, and `value` returns to 0. A subsequent `start` yields a correct 8'hAB.
- **Reset check:** `busy`=0 and `SPI_CS`=1 while idle with no requests; `start` during `rst` is ignored.
